vcm_i2c_responder: RTL and testbench

- I2C target (slave) model of the VCM lens driver.
- Sits on the far end of the SCL/SDA bus from the VCM I2C master; used in loopback rigs and simulation in place of the real actuator.
- Decodes address + 2-byte VCM writes, latches the 16-bit VCM word and the 10-bit lens step, ACKs per byte.
- Oversamples the bus with the system clock; never drives SCL.

---
 rtl/vcm_i2c_pkg.sv | 31 +++
 rtl/i2c_line_filter.sv | 64 ++++++
 rtl/vcm_i2c_responder.sv | 213 +++++++++++++++++++++
 tb/tb_vcm_i2c_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcm_i2c_pkg.sv
// Shared constants, FSM state codes and helpers for the VCM I2C responder.
package vcm_i2c_pkg;

    localparam logic [6:0]  VCM_ADDR_DEF = 7'h0C;
    localparam int unsigned VCM_STEP_MSB = 13;
    localparam int unsigned VCM_STEP_LSB = 4;
    localparam int unsigned VCM_PD_BIT   = 15;

    localparam int unsigned VCM_WORD_W = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_CNT_W  = 4;
    localparam int unsigned STATE_W    = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ADDR     = 3'd1;
    localparam state_t ST_ADDR_ACK = 3'd2;
    localparam state_t ST_WR_BYTE  = 3'd3;
    localparam state_t ST_WR_ACK   = 3'd4;
    localparam state_t ST_RD_BYTE  = 3'd5;
    localparam state_t ST_RD_ACK   = 3'd6;
    localparam state_t ST_IGNORE   = 3'd7;

    // Select the MSB (lsb=0) or LSB (lsb=1) byte of a VCM word.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [VCM_WORD_W-1:0] w,
                                                    input logic lsb);
        return lsb ? w[7:0] : w[15:8];
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus glitch filter for one I2C line; emits filtered level and
// single-cycle rise/fall strobes aligned with the level change.
module i2c_line_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   samp;

    // Level flips once FILT_LEN consecutive synchronised samples disagree with it.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
        samp    = sync_q[SYNC_STAGES-1];
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (samp != level_q) begin
            if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
                level_d = samp;
                rise_d  = samp;
                fall_d  = ~samp;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Registers; an idle bus is high so everything resets to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/vcm_i2c_responder.sv
// I2C target model of the VCM lens driver: decodes address + 2-byte writes,
// latches the 16-bit VCM word and ACKs each byte. Never drives SCL.
// Define VCM_RSP_READBACK_EN to support read transfers; otherwise reads are NACKed.
module vcm_i2c_responder
    import vcm_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = VCM_ADDR_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic        CLK_50,
    input  logic        RESET,
    input  logic        I2C_SCL,
    input  logic        I2C_SDA_IN,
    output logic        I2C_SDA_OE,
    output logic [15:0] VCM_DATA,
    output logic [9:0]  STEP,
    output logic        PD,
    output logic        WR_VALID,
    output logic        BUSY
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_c, stop_c, addr_ok_c;

    state_t                  state_q, state_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]       shift_q, shift_d;
    logic [BYTE_W-1:0]       shadow_q, shadow_d;
    logic                    byte_idx_q, byte_idx_d;
    logic [VCM_WORD_W-1:0]   vcm_data_q, vcm_data_d;
    logic                    wr_valid_q, wr_valid_d;
    logic                    sda_oe_q, sda_oe_d;
    logic                    busy_q, busy_d;
`ifdef VCM_RSP_READBACK_EN
    logic                    rd_sel_q, rd_sel_d;
    logic                    rd_nack_q, rd_nack_d;
    logic [BYTE_W-1:0]       rd_byte_c;
`endif

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(CLK_50), .rst(RESET), .pin(I2C_SCL),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(CLK_50), .rst(RESET), .pin(I2C_SDA_IN),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    // Bus condition detect, byte FSM and register updates.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        shadow_d   = shadow_q;
        byte_idx_d = byte_idx_q;
        vcm_data_d = vcm_data_q;
        wr_valid_d = 1'b0;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
`ifdef VCM_RSP_READBACK_EN
        rd_sel_d   = rd_sel_q;
        rd_nack_d  = rd_nack_q;
        rd_byte_c  = word_byte(vcm_data_q, rd_sel_q);
        addr_ok_c  = 1'b1;
`else
        addr_ok_c  = ~shift_q[0];
`endif
        start_c = sda_fall & scl_lvl;
        stop_c  = sda_rise & scl_lvl;

        if (stop_c || start_c) begin
            state_d    = stop_c ? ST_IDLE : ST_ADDR;
            bit_cnt_d  = '0;
            byte_idx_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q == BIT_CNT_W'(8)) begin
                        bit_cnt_d = '0;
                        if (shift_q[7:1] == DEV_ADDR && addr_ok_c) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d   = 1'b0;
                        bit_cnt_d  = '0;
                        byte_idx_d = 1'b0;
                        state_d    = ST_WR_BYTE;
`ifdef VCM_RSP_READBACK_EN
                        if (shift_q[0]) begin
                            state_d  = ST_RD_BYTE;
                            rd_sel_d = 1'b0;
                            sda_oe_d = ~vcm_data_q[VCM_WORD_W-1];
                        end
`endif
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q == BIT_CNT_W'(8)) begin
                        state_d   = ST_WR_ACK;
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = '0;
                        if (!byte_idx_q) begin
                            shadow_d = shift_q;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_d    = ST_WR_BYTE;
                        sda_oe_d   = 1'b0;
                        byte_idx_d = ~byte_idx_q;
                        if (byte_idx_q) begin
                            vcm_data_d = {shadow_q, shift_q};
                            wr_valid_d = 1'b1;
                        end
                    end
                end
`ifdef VCM_RSP_READBACK_EN
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (scl_fall) begin
                        if (bit_cnt_q == BIT_CNT_W'(8)) begin
                            state_d   = ST_RD_ACK;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            rd_sel_d  = ~rd_sel_q;
                        end else begin
                            sda_oe_d = ~rd_byte_c[3'(BIT_CNT_W'(7) - bit_cnt_q)];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        rd_nack_d = sda_lvl;
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rd_nack_q) begin
                            state_d  = ST_IGNORE;
                            sda_oe_d = 1'b0;
                        end else begin
                            state_d  = ST_RD_BYTE;
                            sda_oe_d = ~rd_byte_c[BYTE_W-1];
                        end
                    end
                end
`endif
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            shadow_q   <= '0;
            byte_idx_q <= 1'b0;
            vcm_data_q <= '0;
            wr_valid_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef VCM_RSP_READBACK_EN
            rd_sel_q   <= 1'b0;
            rd_nack_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            shadow_q   <= shadow_d;
            byte_idx_q <= byte_idx_d;
            vcm_data_q <= vcm_data_d;
            wr_valid_q <= wr_valid_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
`ifdef VCM_RSP_READBACK_EN
            rd_sel_q   <= rd_sel_d;
            rd_nack_q  <= rd_nack_d;
`endif
        end
    end

    assign I2C_SDA_OE = sda_oe_q;
    assign VCM_DATA   = vcm_data_q;
    assign STEP       = vcm_data_q[VCM_STEP_MSB:VCM_STEP_LSB];
    assign PD         = vcm_data_q[VCM_PD_BIT];
    assign WR_VALID   = wr_valid_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_vcm_i2c_responder.sv
// Bench for vcm_i2c_responder: bus-level I2C master, transaction-level model
// and a scoreboard checked on every WR_VALID pulse.
module tb_vcm_i2c_responder;

    localparam int unsigned Q   = 10;
    localparam logic [6:0]  DEV = 7'h0C;
`ifdef VCM_RSP_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m, sda_m, sda_bus;
    logic        oe, wr_valid, pd, busy;
    logic [15:0] vcm_data;
    logic [9:0]  step;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_vcm;
    logic [15:0] mon_w;
    bit          bus_idle;

    assign sda_bus = sda_m & ~oe;

    vcm_i2c_responder dut (
        .CLK_50(clk), .RESET(rst), .I2C_SCL(scl_m), .I2C_SDA_IN(sda_bus),
        .I2C_SDA_OE(oe), .VCM_DATA(vcm_data), .STEP(step), .PD(pd),
        .WR_VALID(wr_valid), .BUSY(busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every WR_VALID pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_valid_unexpected: got word %0h expected no pulse", vcm_data);
            end else begin
                mon_w = exp_q.pop_front();
                check("wr_data", 32'(vcm_data), 32'(mon_w));
                check("wr_step", 32'(step), (32'(mon_w) / 16) % 1024);
                check("wr_pd", 32'(pd), 32'(mon_w) / 32768);
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic bytes_t mk(input int n, input logic [31:0] packed_bytes);
        bytes_t r;
        for (int i = 0; i < n; i++) r.push_back(packed_bytes[8*(n-1-i) +: 8]);
        return r;
    endfunction

    task automatic wait_q(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period; optional single-cycle SDA glitch while SCL is high.
    task automatic bit_cycle(input logic drive, input logic glitch, output logic seen);
        sda_m = drive;
        wait_q(Q);
        scl_m = 1'b1;
        wait_q(Q / 2);
        if (glitch) begin
            sda_m = ~drive;
            wait_q(1);
            sda_m = drive;
        end
        wait_q(Q / 2);
        seen = sda_bus;
        wait_q(Q);
        scl_m = 1'b0;
        wait_q(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], gmask[i], s);
        bit_cycle(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, 1'b0, s);
            b[i] = s;
        end
        bit_cycle(~mack, 1'b0, s);
    endtask

    task automatic send_start();
        sda_m = 1'b0;
        wait_q(Q);
        scl_m = 1'b0;
        wait_q(Q);
        bus_idle = 1'b0;
    endtask

    task automatic send_rstart();
        sda_m = 1'b1;
        wait_q(Q);
        scl_m = 1'b1;
        wait_q(Q);
        sda_m = 1'b0;
        wait_q(Q);
        scl_m = 1'b0;
        wait_q(Q);
    endtask

    task automatic send_stop();
        sda_m = 1'b0;
        wait_q(Q);
        scl_m = 1'b1;
        wait_q(Q);
        sda_m = 1'b1;
        wait_q(2 * Q);
        bus_idle = 1'b1;
    endtask

    // One transaction; the model decides ACKs, read bytes and completed words.
    task automatic txn(input logic [7:0] addr, input bytes_t d, input bit rs_end);
        logic       a;
        logic [7:0] rb;
        bit         acked;
        if (bus_idle) send_start();
        acked = (addr[7:1] == DEV) && (!addr[0] || RB_EN);
        write_byte(addr, 8'h00, a);
        check("addr_ack", 32'(a), 32'(acked));
        if (!addr[0] || RB_EN) check("busy_addr", 32'(busy), 32'(acked));
        if (addr[0]) begin
            if (acked) begin
                for (int k = 0; k < d.size(); k++) begin
                    read_byte(k != d.size() - 1, rb);
                    check("rd_byte", 32'(rb), (k % 2 == 0) ? 32'(model_vcm / 256) : 32'(model_vcm % 256));
                end
                check("oe_after_nack", 32'(oe), 32'd0);
            end
        end else begin
            for (int k = 0; k < d.size(); k++) begin
                if (acked && (k % 2 == 1)) begin
                    model_vcm = {d[k-1], d[k]};
                    exp_q.push_back(model_vcm);
                end
                write_byte(d[k], 8'h00, a);
                check("data_ack", 32'(a), 32'(acked));
            end
        end
        if (rs_end) begin
            send_rstart();
        end else begin
            send_stop();
            check("busy_after_stop", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic       a;
        logic       s;
        logic [7:0] ad;
        int         n;
        int         last;
        bit         rs;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; bus_idle = 1'b1; model_vcm = '0;
        wait_q(4);
        rst = 1'b0;
        wait_q(2);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_vcm", 32'(vcm_data), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_pd", 32'(pd), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        wait_q(2 * Q);

        // Basic write.
        txn(8'h18, mk(2, 32'h4320), 1'b0);
        check("vcm_4320", 32'(vcm_data), 32'h4320);
        check("step_032", 32'(step), 32'h032);
        check("pd_0", 32'(pd), 32'd0);

        // Wrong device: never ACKed, data unchanged.
        txn(8'h1A, mk(2, 32'h55AA), 1'b0);
        check("vcm_wrong_dev", 32'(vcm_data), 32'(model_vcm));

        // Partial word discarded, then a full one.
        txn(8'h18, mk(1, 32'h80), 1'b0);
        check("vcm_partial", 32'(vcm_data), 32'h4320);
        txn(8'h18, mk(2, 32'h8000), 1'b0);
        check("vcm_8000", 32'(vcm_data), 32'h8000);
        check("pd_1", 32'(pd), 32'd1);

        // Two words in one transfer.
        txn(8'h18, mk(4, 32'h001003FF), 1'b0);
        check("vcm_03ff", 32'(vcm_data), 32'h03FF);
        check("step_03f", 32'(step), 32'h03F);

        // Readback (NACKed when the feature is off).
        txn(8'h18, mk(2, 32'h4320), 1'b0);
        txn(8'h19, mk(2, 32'h0), 1'b0);

        // Single-cycle SDA glitches while SCL high must not look like START/STOP.
        send_start();
        write_byte(8'h18, 8'h00, a);
        check("glitch_addr_ack", 32'(a), 32'd1);
        write_byte(8'hA5, 8'h00, a);
        model_vcm = 16'hA5C3;
        exp_q.push_back(model_vcm);
        write_byte(8'hC3, 8'hA0, a);
        check("glitch_data_ack", 32'(a), 32'd1);
        send_stop();
        check("vcm_after_glitch", 32'(vcm_data), 32'hA5C3);

        // Reset mid-byte.
        send_start();
        write_byte(8'h18, 8'h00, a);
        write_byte(8'h12, 8'h00, a);
        for (int i = 0; i < 4; i++) bit_cycle(1'(i % 2), 1'b0, s);
        sda_m = 1'b1;
        rst = 1'b1;
        wait_q(3);
        rst = 1'b0;
        model_vcm = '0;
        wait_q(1);
        check("mid_rst_oe", 32'(oe), 32'd0);
        check("mid_rst_vcm", 32'(vcm_data), 32'd0);
        check("mid_rst_step", 32'(step), 32'd0);
        check("mid_rst_pd", 32'(pd), 32'd0);
        check("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        wait_q(2 * Q);
        write_byte(8'h18, 8'h00, a);
        check("idle_no_ack", 32'(a), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        send_stop();
        txn(8'h18, mk(2, 32'h1234), 1'b0);
        check("vcm_after_rst", 32'(vcm_data), 32'h1234);

        // Randomised transactions, including repeated STARTs.
        last = 13;
        for (int t = 0; t <= last; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    ad = 8'h18;
                2:       ad = 8'h19;
                default: ad = 8'($urandom_range(0, 255));
            endcase
            n  = ad[0] ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 4));
            rs = (t != last) && ($urandom_range(0, 3) == 0);
            txn(ad, mk(n, $urandom), rs);
        end
        check("vcm_final", 32'(vcm_data), 32'(model_vcm));

        wait_q(2 * Q);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
